// File: rtl/axis_result_tx.sv
// axis_result_tx: AXI4-Stream master returning one Tsetlin Machine result per packet (header + class sums).
// Define RESULT_TX_SUMS_EN to append the packed class-sum beats; when it is undefined the packet is the header beat alone.

module axis_result_tx #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_CLASSES = 10,
    parameter int SUM_WIDTH   = 16,
    parameter int CLASS_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             result_valid,
    output logic                             result_ready,
    input  logic [CLASS_WIDTH-1:0]           result_class,
    input  logic [NUM_CLASSES*SUM_WIDTH-1:0] result_sums,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]          m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,
    output logic                             tx_busy,
    output logic [15:0]                      sample_id
);

    localparam int KW = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
`ifdef RESULT_TX_SUMS_EN
    localparam logic [1:0] S_SUMS = 2'd2;
    localparam logic       HDR_LAST = 1'b0;
`else
    localparam logic       HDR_LAST = 1'b1;
`endif

    logic [1:0]            r_state;
    logic                  r_result_ready;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KW-1:0]         r_tkeep;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_tuser;
    logic [15:0]           r_sample_id;

    logic                  w_accept;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_header;

    assign w_accept = (r_state == S_IDLE) && r_result_ready && result_valid;
    assign w_header = DATA_WIDTH'({16'hA5C3, 16'(NUM_CLASSES), r_sample_id, 16'(result_class)});

`ifdef RESULT_TX_SUMS_EN
    localparam int L   = DATA_WIDTH / SUM_WIDTH;
    localparam int NB  = (NUM_CLASSES + L - 1) / L;
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CIW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int BPL = SUM_WIDTH / 8;

    logic [SUM_WIDTH-1:0]  r_sums [NUM_CLASSES];
    logic [BIW-1:0]        r_beat_idx;
    logic [BIW-1:0]        w_next_idx;
    logic [DATA_WIDTH-1:0] w_beat_data;
    logic [KW-1:0]         w_beat_keep;
    logic                  w_beat_last;
    int unsigned           w_lane;

    assign w_done = (r_state == S_SUMS) && m_axis_tready && (r_beat_idx == BIW'(NB - 1));

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                r_sums[k] <= result_sums[k*SUM_WIDTH +: SUM_WIDTH];
            end
        end
    end

    // Next sum beat is prebuilt so it can be registered on the current beat's handshake.
    always_comb begin
        w_next_idx  = (r_state == S_HDR) ? '0 : r_beat_idx + BIW'(1);
        w_beat_data = '0;
        w_beat_keep = '0;
        w_lane      = 0;
        for (int unsigned j = 0; j < L; j++) begin
            w_lane = 32'(w_next_idx) * L + j;
            if (w_lane < NUM_CLASSES) begin
                w_beat_data[j*SUM_WIDTH +: SUM_WIDTH] = r_sums[CIW'(w_lane)];
                w_beat_keep[j*BPL +: BPL]             = '1;
            end
        end
        w_beat_last = (w_next_idx == BIW'(NB - 1));
    end
`else
    logic w_unused_sums;

    assign w_unused_sums = ^result_sums;
    assign w_done        = (r_state == S_HDR) && m_axis_tready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_result_ready <= 1'b0;
            r_busy         <= 1'b0;
            r_tdata        <= '0;
            r_tkeep        <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_tuser        <= 1'b0;
            r_sample_id    <= '0;
`ifdef RESULT_TX_SUMS_EN
            r_beat_idx     <= '0;
`endif
        end else if (w_done) begin
            r_state        <= S_IDLE;
            r_result_ready <= 1'b1;
            r_busy         <= 1'b0;
            r_tdata        <= '0;
            r_tkeep        <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_tuser        <= 1'b0;
            r_sample_id    <= r_sample_id + 16'd1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_result_ready <= 1'b1;
                    if (w_accept) begin
                        r_state        <= S_HDR;
                        r_result_ready <= 1'b0;
                        r_busy         <= 1'b1;
                        r_tdata        <= w_header;
                        r_tkeep        <= '1;
                        r_tvalid       <= 1'b1;
                        r_tlast        <= HDR_LAST;
                        r_tuser        <= 1'b1;
                    end
                end
`ifdef RESULT_TX_SUMS_EN
                S_HDR, S_SUMS: begin
                    if (m_axis_tready) begin
                        r_state    <= S_SUMS;
                        r_beat_idx <= w_next_idx;
                        r_tdata    <= w_beat_data;
                        r_tkeep    <= w_beat_keep;
                        r_tlast    <= w_beat_last;
                        r_tuser    <= 1'b0;
                    end
                end
`else
                S_HDR: begin
                    r_state <= S_HDR;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result_ready  = r_result_ready;
    assign tx_busy       = r_busy;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign sample_id     = r_sample_id;

endmodule
